// File: rtl/pp_seq_pkg.sv
// Shared types and constants for the partial-product row sequencer.
// Imported by the row generator and by the sequencer top.
package pp_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    localparam int ROWS_PER_BEAT = 4;

    function automatic int beats_f(input int width);
        return width / ROWS_PER_BEAT;
    endfunction

endpackage

// File: rtl/pp_row_gen.sv
// Combinational generator for the four shifted partial-product rows of one beat.
// Row j of beat k is a << (4k+j) when multiplier bit 4k+j is set, else zero.
module pp_row_gen
    import pp_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KW    = 1
) (
    input  logic [WIDTH-1:0]                             a,
    input  logic [ROWS_PER_BEAT-1:0]                     b_nib,
    input  logic [KW-1:0]                                k,
    output logic [ROWS_PER_BEAT-1:0][2*WIDTH-1:0]        rows
);

    logic [2*WIDTH-1:0] a_ext;

    assign a_ext = {{WIDTH{1'b0}}, a};

    // The shift 4k+j is simply k with the two-bit row index appended.
    for (genvar j = 0; j < ROWS_PER_BEAT; j++) begin : g_row
        localparam logic [1:0] JJ = 2'(j);
        assign rows[j] = b_nib[j] ? (a_ext << {k, JJ}) : '0;
    end

endmodule

// File: rtl/pp_row_sequencer.sv
// Accepts an operand pair and issues its partial-product rows four per beat
// towards the compressor array; all beat outputs are registered.
module pp_row_sequencer
    import pp_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ZERO_SKIP = 1,
    localparam int BEATS    = beats_f(WIDTH),
    localparam int KW       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_row0,
    output logic [2*WIDTH-1:0] out_row1,
    output logic [2*WIDTH-1:0] out_row2,
    output logic [2*WIDTH-1:0] out_row3,
    output logic [KW-1:0]      out_beat,
    output logic               out_last
);

    localparam logic [KW-1:0] LAST_K = KW'(BEATS - 1);

    state_t                                    state_q, state_d;
    logic [WIDTH-1:0]                          a_q, a_d;
    logic [WIDTH-1:0]                          b_q, b_d;
    logic [KW-1:0]                             k_q, k_d;
    logic [ROWS_PER_BEAT-1:0][2*WIDTH-1:0]     rows_q, rows_d;
    logic                                      last_q, last_d;

    logic [WIDTH-1:0]                          gen_a;
    logic [ROWS_PER_BEAT-1:0]                  gen_nib;
    logic [KW-1:0]                             gen_k;
    logic [ROWS_PER_BEAT-1:0][2*WIDTH-1:0]     gen_rows;
    logic                                      zero_op;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == ISSUE) && !rst;
    assign zero_op   = (ZERO_SKIP != 0) && ((in_a == '0) || (in_b == '0));

    // The generator always prepares the beat that will be registered next:
    // beat 0 of the incoming pair in IDLE, beat k+1 of the captured pair in ISSUE.
    always_comb begin
        gen_a   = a_q;
        gen_k   = k_q + KW'(1);
        gen_nib = b_q[{gen_k, 2'b00} +: ROWS_PER_BEAT];
        if (state_q == IDLE) begin
            gen_a   = in_a;
            gen_k   = '0;
            gen_nib = in_b[ROWS_PER_BEAT-1:0];
        end
    end

    pp_row_gen #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_row_gen (
        .a     (gen_a),
        .b_nib (gen_nib),
        .k     (gen_k),
        .rows  (gen_rows)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        rows_d  = rows_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    k_d     = '0;
                    rows_d  = zero_op ? '0 : gen_rows;
                    last_d  = zero_op || (BEATS == 1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                    end else begin
                        k_d    = gen_k;
                        rows_d = gen_rows;
                        last_d = (gen_k == LAST_K);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            rows_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            rows_q  <= rows_d;
            last_q  <= last_d;
        end
    end

    assign out_row0 = rows_q[0];
    assign out_row1 = rows_q[1];
    assign out_row2 = rows_q[2];
    assign out_row3 = rows_q[3];
    assign out_beat = k_q;
    assign out_last = last_q;

endmodule

// File: tb/tb_pp_row_sequencer.sv
// Scoreboard bench for pp_row_sequencer: accepted pairs are queued and a
// monitor checks every consumed beat and the per-operation row sum.
module tb_pp_row_sequencer;

    localparam int WIDTH = 8;
    localparam int BEATS = WIDTH / 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_row0, out_row1, out_row2, out_row3;
    logic [0:0]  out_beat;
    logic        out_last;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    op_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  rdy_mode = 0;

    pp_row_sequencer #(.WIDTH(WIDTH), .ZERO_SKIP(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row0  (out_row0),
        .out_row1  (out_row1),
        .out_row2  (out_row2),
        .out_row3  (out_row3),
        .out_beat  (out_beat),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    // Downstream readiness: always ready, random, or fully stalled.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: checks held outputs under backpressure and every consumed beat.
    initial begin
        logic [15:0] acc;
        int          beat_idx;
        logic        hold_pending;
        logic [66:0] held, snap;
        logic [15:0] rows [4];
        logic [15:0] exp_row;
        op_t         op;
        logic        zero;
        acc = '0;
        beat_idx = 0;
        hold_pending = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                acc = '0;
                beat_idx = 0;
                hold_pending = 1'b0;
            end else begin
                snap = {out_valid, out_last, out_beat, out_row3, out_row2, out_row1, out_row0};
                if (hold_pending) checkOutput("hold_stable", snap, held);
                hold_pending = out_valid && !out_ready;
                held = snap;
                if (out_valid) begin
                    checkOutput("in_ready_busy", in_ready, 0);
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("unexpected_beat", exp_q.size(), 1);
                        end else begin
                            op = exp_q[0];
                            zero = (op.a == 0) || (op.b == 0);
                            rows = '{out_row0, out_row1, out_row2, out_row3};
                            for (int j = 0; j < 4; j++) begin
                                int r;
                                r = beat_idx * 4 + j;
                                exp_row = 16'h0;
                                if (!zero && r < WIDTH && op.b[r]) exp_row = 16'(op.a) << r;
                                checkOutput($sformatf("row%0d_beat%0d", j, beat_idx), rows[j], exp_row);
                                acc = acc + rows[j];
                            end
                            checkOutput("beat_index", out_beat, beat_idx);
                            checkOutput("last_flag", out_last, zero || (beat_idx == BEATS - 1));
                            if (out_last) begin
                                checkOutput($sformatf("product_%0h_x_%0h", op.a, op.b), acc, 32'(op.a) * 32'(op.b));
                                void'(exp_q.pop_front());
                                acc = '0;
                                beat_idx = 0;
                            end else begin
                                beat_idx++;
                            end
                        end
                    end
                end
            end
        end
    end

    // Presents one pair and holds it until accepted, pushing the expectation.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        int t = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 50) begin
                checkOutput("accept_timeout", in_ready, 1);
                in_valid = 1'b0;
                return;
            end
        end
        exp_q.push_back('{a: a, b: b});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        checkOutput("drain", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_rows", {out_row3, out_row2, out_row1, out_row0}, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_last", out_last, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_in_ready", in_ready, 1);

        @(posedge clk);
        #1;
        applyStimulus(8'hFF, 8'hFF);
        applyStimulus(8'h5A, 8'hA5);
        applyStimulus(8'h00, 8'h37);
        applyStimulus(8'h80, 8'h01);
        drain();

        // Full stall mid beat 0 with ignored input requests.
        rdy_mode = 2;
        applyStimulus(8'h5A, 8'hA5);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            checkOutput("stall_in_ready", in_ready, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        drain();

        // Reset right after the beat 0 handshake abandons the operation.
        applyStimulus(8'hC3, 8'h96);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_no_beat", out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_idle_ready", in_ready, 1);
        checkOutput("rst_idle_valid", out_valid, 0);
        @(posedge clk);
        #1;
        applyStimulus(8'h12, 8'h34);
        drain();

        rdy_mode = 1;
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] a, b;
            a = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            b = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(a, b);
        end
        drain();

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
